reflection_pipe: RTL and testbench

Pipelined, multi-channel reflection engine replacing the combinational per-wall lookup in the physics path. It accepts a ball heading and an arbitrary wall normal (degrees), decides whether the ball is approaching the wall, computes the mirrored heading for any wall orientation, and keeps a saturating per-channel bounce count. It sits between the collision detector, which issues requests tagged with a ball/channel id, and the ball state update, which consumes results through a valid/ready handshake.

---
 rtl/reflection_pipe.sv | 187 ++++++++++++++++++
 tb/tb_reflection_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/reflection_pipe.sv
// reflection_pipe: two-stage pipelined reflection engine.
// S1 registers the request together with its error flag, its approach decision
// and the unreduced mirrored angle. S2 reduces that angle modulo 360 and drives
// the result ports. A per-channel saturating bounce counter is updated when a
// result leaves S2.
module reflection_pipe #(
   parameter int ANGLE_W = 16,
   parameter int NUM_CH  = 4,
   parameter int CNT_W   = 8,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [CH_W-1:0]    req_ch,
   input  logic [ANGLE_W-1:0] req_dir,
   input  logic [ANGLE_W-1:0] req_normal,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CH_W-1:0]    out_ch,
   output logic [ANGLE_W-1:0] out_dir,
   output logic               out_reflected,
   output logic               out_err,
   output logic [CNT_W-1:0]   out_bounce_cnt,
   input  logic               cnt_clr,
   input  logic [CH_W-1:0]    cnt_clr_ch
);

   // Two extra bits hold 2*normal + 540 - dir, which peaks at 1258.
   localparam int W = ANGLE_W + 2;
   localparam logic [W-1:0]       DEG_90    = W'(90);
   localparam logic [W-1:0]       DEG_270   = W'(270);
   localparam logic [W-1:0]       DEG_360   = W'(360);
   localparam logic [W-1:0]       DEG_540   = W'(540);
   localparam logic [ANGLE_W-1:0] ANGLE_LIM = ANGLE_W'(360);

   logic               adv;
   logic [W-1:0]       diff;
   logic [W-1:0]       raw;
   logic [W-1:0]       red;
   logic               req_err;
   logic               req_approach;
   logic               reflect;
   logic               xfer;
   logic [CNT_W-1:0]   cnt_sel;
   logic [CNT_W-1:0]   bounce;

   logic               s1_valid_q,    s1_valid_d;
   logic [CH_W-1:0]    s1_ch_q,       s1_ch_d;
   logic [ANGLE_W-1:0] s1_dir_q,      s1_dir_d;
   logic               s1_err_q,      s1_err_d;
   logic               s1_approach_q, s1_approach_d;
   logic [W-1:0]       s1_raw_q,      s1_raw_d;

   logic               out_valid_q,     out_valid_d;
   logic [CH_W-1:0]    out_ch_q,        out_ch_d;
   logic [ANGLE_W-1:0] out_dir_q,       out_dir_d;
   logic               out_reflected_q, out_reflected_d;
   logic               out_err_q,       out_err_d;

   logic [CNT_W-1:0]   cnt_q [NUM_CH];
   logic [CNT_W-1:0]   cnt_d [NUM_CH];

   // The whole pipe moves together whenever S2 is empty or being drained.
   assign adv       = !out_valid_q || out_ready;
   assign req_ready = adv;

   // S1: classify the request and form the unreduced mirrored heading.
   always_comb begin
      diff = W'(req_dir) + DEG_360 - W'(req_normal);
      if (diff >= DEG_360) begin
         diff = diff - DEG_360;
      end
      req_err      = (req_dir >= ANGLE_LIM) || (req_normal >= ANGLE_LIM);
      req_approach = (diff > DEG_90) && (diff < DEG_270);
      raw          = (W'(req_normal) << 1) + DEG_540 - W'(req_dir);

      s1_valid_d    = s1_valid_q;
      s1_ch_d       = s1_ch_q;
      s1_dir_d      = s1_dir_q;
      s1_err_d      = s1_err_q;
      s1_approach_d = s1_approach_q;
      s1_raw_d      = s1_raw_q;
      if (adv) begin
         s1_valid_d    = req_valid;
         s1_ch_d       = req_ch;
         s1_dir_d      = req_dir;
         s1_err_d      = req_err;
         s1_approach_d = req_approach;
         s1_raw_d      = raw;
      end
   end

   // S2: bring the mirrored angle back into 0..359 and pick the final heading.
   always_comb begin
      red = s1_raw_q;
      for (int k = 0; k < 3; k++) begin
         if (red >= DEG_360) begin
            red = red - DEG_360;
         end
      end
      reflect = s1_approach_q && !s1_err_q;

      out_valid_d     = out_valid_q;
      out_ch_d        = out_ch_q;
      out_dir_d       = out_dir_q;
      out_reflected_d = out_reflected_q;
      out_err_d       = out_err_q;
      if (adv) begin
         out_valid_d     = s1_valid_q;
         out_ch_d        = s1_ch_q;
         out_dir_d       = reflect ? ANGLE_W'(red) : s1_dir_q;
         out_reflected_d = reflect;
         out_err_d       = s1_err_q;
      end
   end

   // Bounce counters: report the saturated post-result count, commit it on
   // transfer, and let a clear win over an increment on the same channel.
   always_comb begin
      cnt_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (out_ch_q == CH_W'(i)) begin
            cnt_sel = cnt_q[i];
         end
      end
      if (out_reflected_q && (cnt_sel != {CNT_W{1'b1}})) begin
         bounce = cnt_sel + CNT_W'(1);
      end else begin
         bounce = cnt_sel;
      end

      xfer = out_valid_q && out_ready;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (cnt_clr && (cnt_clr_ch == CH_W'(i))) begin
            cnt_d[i] = '0;
         end else if (xfer && (out_ch_q == CH_W'(i))) begin
            cnt_d[i] = bounce;
         end
      end
   end

   // State registers; reset empties the pipe and zeroes every counter at once.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         s1_valid_q      <= 1'b0;
         s1_ch_q         <= '0;
         s1_dir_q        <= '0;
         s1_err_q        <= 1'b0;
         s1_approach_q   <= 1'b0;
         s1_raw_q        <= '0;
         out_valid_q     <= 1'b0;
         out_ch_q        <= '0;
         out_dir_q       <= '0;
         out_reflected_q <= 1'b0;
         out_err_q       <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         s1_valid_q      <= s1_valid_d;
         s1_ch_q         <= s1_ch_d;
         s1_dir_q        <= s1_dir_d;
         s1_err_q        <= s1_err_d;
         s1_approach_q   <= s1_approach_d;
         s1_raw_q        <= s1_raw_d;
         out_valid_q     <= out_valid_d;
         out_ch_q        <= out_ch_d;
         out_dir_q       <= out_dir_d;
         out_reflected_q <= out_reflected_d;
         out_err_q       <= out_err_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign out_valid      = out_valid_q;
   assign out_ch         = out_ch_q;
   assign out_dir        = out_dir_q;
   assign out_reflected  = out_reflected_q;
   assign out_err        = out_err_q;
   assign out_bounce_cnt = bounce;

endmodule

// File: tb/tb_reflection_pipe.sv
// tb_reflection_pipe: directed checks of reflection_pipe with 2-bit counters
// so that saturation is reached after only a few bounces.
module tb_reflection_pipe;

   localparam int ANGLE_W = 16;
   localparam int NUM_CH  = 4;
   localparam int CNT_W   = 2;
   localparam int CH_W    = 2;

   logic               clk = 1'b0;
   logic               rst;
   logic               req_valid;
   logic               req_ready;
   logic [CH_W-1:0]    req_ch;
   logic [ANGLE_W-1:0] req_dir;
   logic [ANGLE_W-1:0] req_normal;
   logic               out_valid;
   logic               out_ready;
   logic [CH_W-1:0]    out_ch;
   logic [ANGLE_W-1:0] out_dir;
   logic               out_reflected;
   logic               out_err;
   logic [CNT_W-1:0]   out_bounce_cnt;
   logic               cnt_clr;
   logic [CH_W-1:0]    cnt_clr_ch;

   int checks   = 0;
   int failures = 0;

   reflection_pipe #(
      .ANGLE_W(ANGLE_W),
      .NUM_CH (NUM_CH),
      .CNT_W  (CNT_W)
   ) dut (
      .clk_in        (clk),
      .rst_in        (rst),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_ch        (req_ch),
      .req_dir       (req_dir),
      .req_normal    (req_normal),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_ch        (out_ch),
      .out_dir       (out_dir),
      .out_reflected (out_reflected),
      .out_err       (out_err),
      .out_bounce_cnt(out_bounce_cnt),
      .cnt_clr       (cnt_clr),
      .cnt_clr_ch    (cnt_clr_ch)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Guard against a hung run.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [CH_W-1:0] ch,
                                input logic [ANGLE_W-1:0] dir, input logic [ANGLE_W-1:0] nrm);
      req_valid  = v;
      req_ch     = ch;
      req_dir    = dir;
      req_normal = nrm;
   endtask

   task automatic checkOutput(input string tag, input logic [CH_W-1:0] ch,
                              input logic [ANGLE_W-1:0] dir, input logic refl,
                              input logic err, input logic [CNT_W-1:0] cnt);
      check({tag, ".valid"}, 32'(out_valid), 32'd1);
      check({tag, ".ch"},    32'(out_ch), 32'(ch));
      check({tag, ".dir"},   32'(out_dir), 32'(dir));
      check({tag, ".refl"},  32'(out_reflected), 32'(refl));
      check({tag, ".err"},   32'(out_err), 32'(err));
      check({tag, ".cnt"},   32'(out_bounce_cnt), 32'(cnt));
   endtask

   // One request through an unstalled pipe; the optional clear of channel 2
   // lands on the same edge that drains the previous result.
   task automatic sendOne(input string tag, input logic [CH_W-1:0] ch,
                          input logic [ANGLE_W-1:0] dir, input logic [ANGLE_W-1:0] nrm,
                          input logic [ANGLE_W-1:0] exp_dir, input logic exp_refl,
                          input logic exp_err, input logic [CNT_W-1:0] exp_cnt,
                          input logic clr);
      applyStimulus(1'b1, ch, dir, nrm);
      cnt_clr    = clr;
      cnt_clr_ch = 2'd2;
      @(posedge clk); #1;
      applyStimulus(1'b0, '0, '0, '0);
      cnt_clr = 1'b0;
      @(posedge clk); #1;
      checkOutput(tag, ch, exp_dir, exp_refl, exp_err, exp_cnt);
   endtask

   // Directed sequence.
   initial begin
      rst        = 1'b1;
      out_ready  = 1'b1;
      cnt_clr    = 1'b0;
      cnt_clr_ch = '0;
      applyStimulus(1'b0, '0, '0, '0);
      #1;
      check("rst.valid", 32'(out_valid), 32'd0);
      check("rst.ch",    32'(out_ch), 32'd0);
      check("rst.dir",   32'(out_dir), 32'd0);
      check("rst.refl",  32'(out_reflected), 32'd0);
      check("rst.err",   32'(out_err), 32'd0);
      check("rst.cnt",   32'(out_bounce_cnt), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("post_rst.ready", 32'(req_ready), 32'd1);

      sendOne("vert_refl",  2'd0,  30, 180, 150, 1'b1, 1'b0, 2'd1, 1'b0);
      sendOne("vert_away",  2'd0, 120, 180, 120, 1'b0, 1'b0, 2'd1, 1'b0);
      sendOne("floor",      2'd1, 300,  90,  60, 1'b1, 1'b0, 2'd1, 1'b0);
      sendOne("diag",       2'd1, 300, 135, 150, 1'b1, 1'b0, 2'd2, 1'b0);
      sendOne("parallel",   2'd1,   0,  90,   0, 1'b0, 1'b0, 2'd2, 1'b0);
      sendOne("err_dir",    2'd3, 400, 180, 400, 1'b0, 1'b1, 2'd0, 1'b0);
      sendOne("after_err",  2'd3,  30, 180, 150, 1'b1, 1'b0, 2'd1, 1'b0);

      for (int i = 0; i < 5; i++) begin
         sendOne($sformatf("sat%0d", i), 2'd2, 30, 180, 150, 1'b1, 1'b0,
                 (i < 2) ? 2'(i + 1) : 2'd3, 1'b0);
      end
      sendOne("clr_same",   2'd2,  30, 180, 150, 1'b1, 1'b0, 2'd1, 1'b1);
      sendOne("ch0_a",      2'd0,  30, 180, 150, 1'b1, 1'b0, 2'd2, 1'b0);
      sendOne("clr_other",  2'd2,  30, 180, 150, 1'b1, 1'b0, 2'd1, 1'b1);
      sendOne("ch0_b",      2'd0,  30, 180, 150, 1'b1, 1'b0, 2'd3, 1'b0);

      // Drain, then push three requests into a stalled output.
      @(posedge clk); #1;
      check("drain.valid", 32'(out_valid), 32'd0);
      out_ready = 1'b0;
      applyStimulus(1'b1, 2'd0, 30, 180);
      #1;
      check("bp.ready_a", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      applyStimulus(1'b1, 2'd1, 120, 180);
      check("bp.ready_b", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      applyStimulus(1'b1, 2'd3, 300, 90);
      check("bp.ready_c", 32'(req_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check($sformatf("bp.hold%0d.ready", i), 32'(req_ready), 32'd0);
         check($sformatf("bp.hold%0d.valid", i), 32'(out_valid), 32'd1);
         check($sformatf("bp.hold%0d.dir", i),   32'(out_dir), 32'd150);
      end
      out_ready = 1'b1;
      #1;
      check("bp.release_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      applyStimulus(1'b0, '0, '0, '0);
      check("bp.b.valid", 32'(out_valid), 32'd1);
      check("bp.b.ch",    32'(out_ch), 32'd1);
      check("bp.b.dir",   32'(out_dir), 32'd120);
      @(posedge clk); #1;
      check("bp.c.valid", 32'(out_valid), 32'd1);
      check("bp.c.ch",    32'(out_ch), 32'd3);
      check("bp.c.dir",   32'(out_dir), 32'd60);
      @(posedge clk); #1;
      check("bp.empty", 32'(out_valid), 32'd0);

      // Reset with two requests in flight.
      applyStimulus(1'b1, 2'd1, 30, 180);
      @(posedge clk); #1;
      applyStimulus(1'b1, 2'd0, 300, 90);
      @(posedge clk); #1;
      check("mid.valid_before", 32'(out_valid), 32'd1);
      rst = 1'b1;
      applyStimulus(1'b0, '0, '0, '0);
      #1;
      check("mid.valid", 32'(out_valid), 32'd0);
      check("mid.dir",   32'(out_dir), 32'd0);
      check("mid.ch",    32'(out_ch), 32'd0);
      check("mid.refl",  32'(out_reflected), 32'd0);
      check("mid.cnt",   32'(out_bounce_cnt), 32'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check($sformatf("mid.stale%0d", i), 32'(out_valid), 32'd0);
      end
      sendOne("post_mid", 2'd1, 30, 180, 150, 1'b1, 1'b0, 2'd1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
